// File: rtl/bus_arbiter_6502.sv
// bus_arbiter_6502
//   Shares the single external memory bus of a 6502 core between the CPU and
//   one DMA requester. The CPU is stalled through RDY while DMA owns the bus.
//   DMA bursts are bounded by MAX_BURST and followed by CPU_MIN cycles of
//   guaranteed CPU ownership. A debug halt freezes the CPU indefinitely while
//   DMA may still be served.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cpu_ab/cpu_do/cpu_we        CPU bus request (from core AB/DO/WE)
//   cpu_rdy                     to core RDY (0 = CPU frozen), registered
//   cpu_di                      to core DI, straight from bus_di
//   dma_req/addr/wdata/we       DMA request and access attributes
//   dma_gnt                     DMA access is on the bus this cycle (registered)
//   dma_ack/dma_rdata           completion pulse and read data, one cycle later
//   dbg_halt                    debug halt of the CPU
//   bus_ab/do/we/oeb, bus_di    chip pins; bus_di has one cycle of latency
module bus_arbiter_6502 #(
   parameter int MAX_BURST = 8,
   parameter int CPU_MIN   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_ab,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic [7:0]  cpu_di,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   input  logic        dma_we,
   output logic        dma_gnt,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   input  logic        dbg_halt,
   output logic [15:0] bus_ab,
   output logic [7:0]  bus_do,
   output logic        bus_we,
   output logic        bus_oeb,
   input  logic [7:0]  bus_di
);

   typedef enum logic [1:0] {
      ST_CPU,
      ST_DMA,
      ST_HALT,
      ST_COOL
   } state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);
   localparam logic [3:0] COOL_LAST  = 4'(CPU_MIN - 1);
   // Where a burst or a halt hands the bus back to the CPU.
   localparam state_t     RESUME_ST  = (CPU_MIN == 0) ? ST_CPU : ST_COOL;

   state_t      state_reg;
   logic        cpu_rdy_reg;
   logic        dma_gnt_reg;
   logic        dma_ack_reg;
   logic        ack_we_reg;     // the acknowledged access was a write
   logic [7:0]  burst_cnt_reg;  // grants issued in the current DMA burst
   logic [3:0]  cool_cnt_reg;
   logic [15:0] last_ab_reg;    // address parked on the pins when nobody drives

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_CPU;
         cpu_rdy_reg   <= 1'b1;
         dma_gnt_reg   <= 1'b0;
         dma_ack_reg   <= 1'b0;
         ack_we_reg    <= 1'b0;
         burst_cnt_reg <= 8'd0;
         cool_cnt_reg  <= 4'd0;
         last_ab_reg   <= 16'h0000;
      end else begin
         dma_ack_reg <= dma_gnt_reg;
         ack_we_reg  <= dma_gnt_reg & dma_we;
         last_ab_reg <= bus_ab;
         case (state_reg)
            ST_CPU: begin
               if (dbg_halt) begin
                  // Halt wins over DMA; a simultaneous request is served in HALT.
                  state_reg   <= ST_HALT;
                  cpu_rdy_reg <= 1'b0;
                  dma_gnt_reg <= dma_req;
               end else if (dma_req) begin
                  state_reg     <= ST_DMA;
                  cpu_rdy_reg   <= 1'b0;
                  dma_gnt_reg   <= 1'b1;
                  burst_cnt_reg <= 8'd1;
               end else begin
                  dma_gnt_reg <= 1'b0;
               end
            end
            ST_DMA: begin
               if (dbg_halt) begin
                  state_reg     <= ST_HALT;
                  dma_gnt_reg   <= dma_req;
                  burst_cnt_reg <= 8'd0;
               end else if (!dma_req || burst_cnt_reg >= BURST_LAST) begin
                  // The grant on the bus now is the last one of this burst.
                  state_reg     <= RESUME_ST;
                  cpu_rdy_reg   <= 1'b1;
                  dma_gnt_reg   <= 1'b0;
                  burst_cnt_reg <= 8'd0;
                  cool_cnt_reg  <= 4'd0;
               end else begin
                  dma_gnt_reg   <= 1'b1;
                  burst_cnt_reg <= burst_cnt_reg + 8'd1;
               end
            end
            ST_HALT: begin
               if (!dbg_halt) begin
                  state_reg    <= RESUME_ST;
                  cpu_rdy_reg  <= 1'b1;
                  dma_gnt_reg  <= 1'b0;
                  cool_cnt_reg <= 4'd0;
               end else begin
                  dma_gnt_reg <= dma_req;
               end
            end
            default: begin // ST_COOL: the CPU keeps the bus, DMA requests wait
               dma_gnt_reg <= 1'b0;
               if (dbg_halt) begin
                  state_reg   <= ST_HALT;
                  cpu_rdy_reg <= 1'b0;
                  dma_gnt_reg <= dma_req;
               end else if (cool_cnt_reg >= COOL_LAST) begin
                  state_reg    <= ST_CPU;
                  cool_cnt_reg <= 4'd0;
               end else begin
                  cool_cnt_reg <= cool_cnt_reg + 4'd1;
               end
            end
         endcase
      end
   end

   // Pin mux. While the CPU is stalled its frozen write strobe never reaches
   // the pins; it reappears in the cycle cpu_rdy returns high.
   always_comb begin
      bus_ab = last_ab_reg;
      bus_do = 8'h00;
      bus_we = 1'b0;
      if (cpu_rdy_reg) begin
         bus_ab = cpu_ab;
         bus_do = cpu_do;
         bus_we = cpu_we;
      end else if (dma_gnt_reg) begin
         bus_ab = dma_addr;
         bus_do = dma_wdata;
         bus_we = dma_we;
      end
   end

   assign bus_oeb   = ~bus_we;
   assign cpu_rdy   = cpu_rdy_reg;
   assign cpu_di    = bus_di;
   assign dma_gnt   = dma_gnt_reg;
   assign dma_ack   = dma_ack_reg;
   // Pin read data arrives exactly in the ack cycle, so it is passed through.
   assign dma_rdata = (dma_ack_reg && !ack_we_reg) ? bus_di : 8'h00;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// tb_bus_arbiter_6502
//   Directed bench for bus_arbiter_6502 (MAX_BURST=8, CPU_MIN=2). Inputs are
//   driven 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_bus_arbiter_6502;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_ab;
   logic [7:0]  cpu_do;
   logic        cpu_we;
   logic        cpu_rdy;
   logic [7:0]  cpu_di;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic        dma_gnt;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic        dbg_halt;
   logic [15:0] bus_ab;
   logic [7:0]  bus_do;
   logic        bus_we;
   logic        bus_oeb;
   logic [7:0]  bus_di;

   int checks = 0;
   int errors = 0;

   bus_arbiter_6502 #(.MAX_BURST(8), .CPU_MIN(2)) dut (
      .clk(clk), .rst(rst),
      .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
      .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
      .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dbg_halt(dbg_halt),
      .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we), .bus_oeb(bus_oeb),
      .bus_di(bus_di)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         dma_req = 1'b0; dbg_halt = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      settle();
      if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", cpu_rdy); end
      checks++;
      if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", dma_gnt); end
      checks++;
      if (dma_ack !== 1'b0 || dma_rdata !== 8'h00) begin errors++; $display("FAIL reset_ack: got ack=%b rdata=%h expected 0/00", dma_ack, dma_rdata); end
      checks++;
      if (bus_we !== 1'b0 || bus_oeb !== 1'b1) begin errors++; $display("FAIL reset_bus: got we=%b oeb=%b expected 0/1", bus_we, bus_oeb); end
      checks++;
      rst = 1'b0;
      idle(2);
      $display("test_reset done");
   endtask

   // Request held for three cycles starting at C=10.
   task automatic test_short_burst();
      logic [3:0] exp_rdy, exp_gnt, exp_ack;
      exp_rdy = 4'b1000; // cycles 11..14, bit index = cycle-11
      exp_gnt = 4'b0111;
      exp_ack = 4'b1110;
      cyc(); // C=10
      cpu_ab = 16'h1234; dma_addr = 16'h3000; dma_we = 1'b0; dma_req = 1'b1;
      settle();
      if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0 || bus_ab !== 16'h1234) begin
         errors++; $display("FAIL short_c10: got rdy=%b gnt=%b ab=%h expected 1/0/1234", cpu_rdy, dma_gnt, bus_ab);
      end
      checks++;
      for (int c = 0; c < 4; c++) begin // C=11..14
         cyc();
         dma_req = (c < 2);
         settle();
         if (cpu_rdy !== exp_rdy[c] || dma_gnt !== exp_gnt[c] || dma_ack !== exp_ack[c]) begin
            errors++; $display("FAIL short_c%0d: got rdy=%b gnt=%b ack=%b expected %b/%b/%b",
                               11 + c, cpu_rdy, dma_gnt, dma_ack, exp_rdy[c], exp_gnt[c], exp_ack[c]);
         end
         checks++;
      end
      if (bus_ab !== 16'h1234) begin errors++; $display("FAIL short_resume_ab: got %h expected 1234", bus_ab); end
      checks++;
      idle(4);
      $display("test_short_burst done");
   endtask

   // One DMA read of 0xC000 followed by a DMA write of 0x00 to 0x0200.
   task automatic test_dma_rw();
      cyc();
      dma_req = 1'b1; dma_addr = 16'hC000; dma_we = 1'b0;
      cyc();
      dma_req = 1'b1; bus_di = 8'h00;
      settle();
      if (dma_gnt !== 1'b1 || bus_ab !== 16'hC000 || bus_we !== 1'b0) begin
         errors++; $display("FAIL rw_read_addr: got gnt=%b ab=%h we=%b expected 1/c000/0", dma_gnt, bus_ab, bus_we);
      end
      checks++;
      cyc();
      dma_req = 1'b0; dma_addr = 16'h0200; dma_we = 1'b1; dma_wdata = 8'h00; bus_di = 8'h5A;
      settle();
      if (dma_ack !== 1'b1 || dma_rdata !== 8'h5A) begin
         errors++; $display("FAIL rw_read_data: got ack=%b rdata=%h expected 1/5a", dma_ack, dma_rdata);
      end
      checks++;
      if (bus_we !== 1'b1 || bus_oeb !== 1'b0 || bus_ab !== 16'h0200 || bus_do !== 8'h00) begin
         errors++; $display("FAIL rw_write_bus: got we=%b oeb=%b ab=%h do=%h expected 1/0/0200/00", bus_we, bus_oeb, bus_ab, bus_do);
      end
      checks++;
      cyc();
      dma_we = 1'b0; bus_di = 8'hFF;
      settle();
      if (dma_ack !== 1'b1 || dma_rdata !== 8'h00 || cpu_rdy !== 1'b1) begin
         errors++; $display("FAIL rw_write_ack: got ack=%b rdata=%h rdy=%b expected 1/00/1", dma_ack, dma_rdata, cpu_rdy);
      end
      checks++;
      idle(4);
      $display("test_dma_rw done");
   endtask

   // CPU presents a write while DMA holds the bus; it must appear only at resume.
   task automatic test_cpu_write_stall();
      cyc();
      cpu_ab = 16'h0250; cpu_we = 1'b0; dma_req = 1'b1; dma_addr = 16'h6000; dma_we = 1'b0;
      settle();
      if (bus_ab !== 16'h0250) begin errors++; $display("FAIL stall_pre_ab: got %h expected 0250", bus_ab); end
      checks++;
      cyc();
      cpu_ab = 16'h0300; cpu_we = 1'b1; cpu_do = 8'h77; dma_req = 1'b0;
      settle();
      if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1 || bus_we !== 1'b0 || bus_ab !== 16'h6000) begin
         errors++; $display("FAIL stall_no_cpu_we: got rdy=%b gnt=%b we=%b ab=%h expected 0/1/0/6000", cpu_rdy, dma_gnt, bus_we, bus_ab);
      end
      checks++;
      cyc();
      settle();
      if (cpu_rdy !== 1'b1 || bus_we !== 1'b1 || bus_ab !== 16'h0300 || bus_do !== 8'h77) begin
         errors++; $display("FAIL stall_resume_write: got rdy=%b we=%b ab=%h do=%h expected 1/1/0300/77", cpu_rdy, bus_we, bus_ab, bus_do);
      end
      checks++;
      idle(4);
      $display("test_cpu_write_stall done");
   endtask

   // dma_req stuck high: bursts of 8 grants separated by CPU-owned cycles.
   task automatic test_burst_limit();
      int run, gap, bursts;
      logic prev_gnt, seen_burst;
      run = 0; gap = 0; bursts = 0; prev_gnt = 1'b0; seen_burst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         dma_req = 1'b1; dma_addr = 16'h5000 + 16'(i); dma_we = 1'b0;
         settle();
         if (dma_gnt === 1'b1 && cpu_rdy === 1'b1) begin
            errors++; $display("FAIL burst_overlap: cycle %0d gnt=%b rdy=%b", i, dma_gnt, cpu_rdy);
         end
         checks++;
         if (dma_gnt === 1'b1) begin
            if (!prev_gnt && seen_burst) begin
               // cooldown cycles, plus at most the arbitration cycle
               if (gap < 2 || gap > 3) begin errors++; $display("FAIL burst_gap: got %0d expected 2..3", gap); end
               checks++;
            end
            run++;
         end else begin
            if (prev_gnt) begin
               if (run != 8) begin errors++; $display("FAIL burst_len: got %0d expected 8", run); end
               checks++;
               bursts++; seen_burst = 1'b1; run = 0; gap = 0;
            end
            if (cpu_rdy === 1'b1) gap++;
         end
         prev_gnt = dma_gnt;
      end
      if (bursts < 3) begin errors++; $display("FAIL burst_count: got %0d expected >=3", bursts); end
      checks++;
      idle(12);
      $display("test_burst_limit done");
   endtask

   // Halt at C=20 together with 20 request cycles, then release.
   task automatic test_halt();
      int grants;
      grants = 0;
      cyc(); // C=20
      dbg_halt = 1'b1; dma_req = 1'b1; dma_addr = 16'h4000; dma_we = 1'b0;
      cpu_ab = 16'h0777; cpu_we = 1'b0;
      settle();
      if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL halt_c20_rdy: got %b expected 1", cpu_rdy); end
      checks++;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         dma_req = (i < 20); dma_addr = 16'h4000 + 16'(i);
         settle();
         if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL halt_rdy: cycle %0d got %b expected 0", 20 + i, cpu_rdy); end
         checks++;
         if (dma_gnt === 1'b1) grants++;
      end
      if (grants != 20) begin errors++; $display("FAIL halt_grants: got %0d expected 20", grants); end
      checks++;
      cyc();
      dbg_halt = 1'b0;
      settle();
      if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b0 || bus_we !== 1'b0 || bus_ab !== 16'h4014) begin
         errors++; $display("FAIL halt_idle: got rdy=%b gnt=%b we=%b ab=%h expected 0/0/0/4014", cpu_rdy, dma_gnt, bus_we, bus_ab);
      end
      checks++;
      cyc();
      dma_req = 1'b1;
      settle();
      if (cpu_rdy !== 1'b1 || bus_ab !== 16'h0777) begin
         errors++; $display("FAIL halt_release: got rdy=%b ab=%h expected 1/0777", cpu_rdy, bus_ab);
      end
      checks++;
      for (int k = 0; k < 2; k++) begin
         cyc();
         settle();
         if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL cool_ignore_req: step %0d got gnt=%b rdy=%b expected 0/1", k, dma_gnt, cpu_rdy);
         end
         checks++;
      end
      cyc();
      dma_req = 1'b0;
      settle();
      if (dma_gnt !== 1'b1 || cpu_rdy !== 1'b0) begin
         errors++; $display("FAIL cool_rearb: got gnt=%b rdy=%b expected 1/0", dma_gnt, cpu_rdy);
      end
      checks++;
      idle(5);
      $display("test_halt done");
   endtask

   // Reset lands while the third grant is on the bus.
   task automatic test_reset_mid_burst();
      cyc();
      dma_req = 1'b1; dma_addr = 16'h7000; dma_we = 1'b0;
      cyc(); cyc(); cyc();
      settle();
      if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_pre_gnt: got %b expected 1", dma_gnt); end
      checks++;
      rst = 1'b1;
      cyc();
      rst = 1'b0; dma_req = 1'b0;
      settle();
      if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0 || dma_ack !== 1'b0) begin
         errors++; $display("FAIL rstmid_state: got rdy=%b gnt=%b ack=%b expected 1/0/0", cpu_rdy, dma_gnt, dma_ack);
      end
      checks++;
      cyc();
      settle();
      if (dma_ack !== 1'b0 || dma_gnt !== 1'b0) begin
         errors++; $display("FAIL rstmid_no_ack: got ack=%b gnt=%b expected 0/0", dma_ack, dma_gnt);
      end
      checks++;
      idle(3);
      $display("test_reset_mid_burst done");
   endtask

   initial begin
      rst = 1'b1; cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
      dma_req = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00; dma_we = 1'b0;
      dbg_halt = 1'b0; bus_di = 8'h00;
      test_reset();
      test_short_burst();
      test_dma_rw();
      test_cpu_write_stall();
      test_burst_limit();
      test_halt();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
